// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming helpers and defaults for encoder and decoder.
// SECDED_BIT reflects the SECDED_EN build macro (overall parity bit).
package hamming_pkg;

    localparam int DATA_W_4  = 4;
    localparam int DATA_W_11 = 11;
    localparam int DATA_W_26 = 26;
    localparam int DATA_W_57 = 57;

`ifdef SECDED_EN
    localparam int SECDED_BIT = 1;
`else
    localparam int SECDED_BIT = 0;
`endif

    function automatic int calc_parity_w(input int data_w);
        int p;
        p = 7;
        for (int i = 7; i >= 1; i--)
            if ((1 << i) >= data_w + i + 1) p = i;
        return p;
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Bit pos-1 set for every codeword position pos covered by parity p_k.
    function automatic logic [63:0] cover_mask(input int k);
        logic [63:0] m;
        m = '0;
        for (int pos = 1; pos <= 64; pos++)
            m[pos-1] = ((pos >> k) & 1) == 1;
        return m;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// hamming_parity_gen: scatters data bits into non-power-of-two positions and
// fills each position 2^k with its even parity bit (purely combinational).
module hamming_parity_gen
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    localparam int P_W    = calc_parity_w(DATA_W),
    localparam int N      = DATA_W + P_W
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [N-1:0]      o_code
);

    logic [N-1:0]   w_scatter;
    logic [P_W-1:0] w_par;

    genvar i, k;

    // Data index for position i is i minus the number of parity slots at or below it.
    for (i = 1; i <= N; i++) begin : g_pos
        if (is_pow2(i)) begin : g_par_slot
            assign w_scatter[i-1] = 1'b0;
        end else begin : g_data_slot
            assign w_scatter[i-1] = i_data[i-$clog2(i+1)-1];
        end
    end

    for (k = 0; k < P_W; k++) begin : g_pk
        localparam logic [63:0] MASK = cover_mask(k);
        assign w_par[k] = ^(w_scatter & MASK[N-1:0]);
    end

    always_comb begin
        o_code = w_scatter;
        for (int j = 0; j < P_W; j++)
            o_code[(1 << j) - 1] = w_par[j];
    end

endmodule

// File: rtl/hamming_encoder_param.sv
// hamming_encoder_param: valid/ready Hamming encoder with a 2-entry output FIFO
// and accepted-word counter; define SECDED_EN to append an overall parity bit.
module hamming_encoder_param
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int P_W    = calc_parity_w(DATA_W),
    localparam int CODE_W = DATA_W + P_W + SECDED_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [DATA_W+P_W-1:0] w_base;
    logic [CODE_W-1:0]     w_code;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_count_nxt;

    logic [CODE_W-1:0]     r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_in_ready;
    logic [CNT_W-1:0]      r_word_cnt;

    hamming_parity_gen #(.DATA_W(DATA_W)) u_parity_gen (
        .i_data (data_in),
        .o_code (w_base)
    );

`ifdef SECDED_EN
    assign w_code = {^w_base, w_base};
`else
    assign w_code = w_base;
`endif

    // in_ready is registered from the post-update count, so out_ready never reaches it.
    assign in_ready    = r_in_ready & ena;
    assign out_valid   = r_count != 2'd0;
    assign code_out    = out_valid ? r_mem[r_rd_ptr] : '0;
    assign word_cnt    = r_word_cnt;
    assign w_push      = ena & in_valid & r_in_ready;
    assign w_pop       = ena & out_valid & out_ready;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= ~r_wr_ptr;
                r_word_cnt      <= r_word_cnt + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count    <= w_count_nxt;
            r_in_ready <= w_count_nxt < 2'd2;
        end
    end

endmodule

// File: tb/tb_hamming_encoder_param.sv
// tb_hamming_encoder_param: randomized scenarios checked against a queue-based
// reference model; DUT built with DATA_W=4, CNT_W=4 so counter wrap is exercised.
module tb_hamming_encoder_param;

`ifdef SECDED_EN
    localparam int CW = 8;
`else
    localparam int CW = 7;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] code_out;
    logic [3:0]    word_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CW-1:0] q[$];
    int            m_cnt = 0;
    logic          m_rdy = 1'b0;

    hamming_encoder_param #(.DATA_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code_out  (code_out),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoder: walk positions 1..7, fill data, then even parity per group.
    function automatic logic [CW-1:0] enc(input logic [3:0] d);
        logic [7:0] c;
        int di;
        logic p;
        c  = '0;
        di = 0;
        for (int pos = 1; pos <= 7; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[di];
                di++;
            end
        for (int k = 0; k < 3; k++) begin
            p = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) p = p ^ c[pos-1];
            c[(1 << k) - 1] = p;
        end
`ifdef SECDED_EN
        c[7] = ^c[6:0];
`endif
        return c[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] head();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    task automatic tick(input logic iv, input logic [3:0] d, input logic orr, input logic en);
        logic acc, pop;
        in_valid  = iv;
        data_in   = d;
        out_ready = orr;
        ena       = en;
        @(posedge clk);
        acc = en && iv && m_rdy;
        pop = en && (q.size() != 0) && orr;
        if (pop) q.delete(0);
        if (acc) begin
            q.push_back(enc(d));
            m_cnt = (m_cnt + 1) % 16;
        end
        if (en) m_rdy = q.size() < 2;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 4; c++) tick(1'b0, 4'h0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || code_out !== '0 || word_cnt !== 4'd0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b code_out=%h word_cnt=%0d in_ready=%b, required 0/0/0/0",
                     out_valid, code_out, word_cnt, in_ready);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: in_ready=%b, required 0", in_ready);
        end
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [CW-1:0] lit;
        lit = 'h55;
        tick(1'b1, 4'b1011, 1'b1, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || code_out !== lit || code_out !== head()) begin
            n_fail++;
            $display("FAIL basic_1011: out_valid=%b code_out=%h, required 1 / %h", out_valid, code_out, lit);
        end
        n_tests++;
        if (word_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_word_cnt: word_cnt=%0d, required 1", word_cnt);
        end
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drained: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [3:0]    din [3];
        logic [CW-1:0] lit [3];
        din = '{4'hF, 4'hB, 4'h0};
`ifdef SECDED_EN
        lit = '{8'hFF, 8'h55, 8'h00};
`else
        lit = '{7'h7F, 7'h55, 7'h00};
`endif
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, din[i], 1'b1, 1'b1);
            n_tests++;
            if (code_out !== lit[i] || code_out !== head() || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL vector_%h: code_out=%h out_valid=%b, required %h / 1", din[i], code_out, out_valid, lit[i]);
            end
        end
        drain();
    endtask

    task automatic test_back_pressure();
        logic [CW-1:0] got[$];
        logic          sent3;
        tick(1'b1, 4'h1, 1'b0, 1'b1);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after_one: in_ready=%b, required 1", in_ready);
        end
        tick(1'b1, 4'h2, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || code_out !== enc(4'h1) || word_cnt !== m_cnt[3:0]) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: in_ready=%b out_valid=%b code_out=%h word_cnt=%0d, required 0/1/%h/%0d",
                         c, in_ready, out_valid, code_out, word_cnt, enc(4'h1), m_cnt);
            end
            tick(1'b1, 4'h3, 1'b0, 1'b1);
        end
        sent3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) got.push_back(code_out);
            if (in_ready && !sent3) begin
                tick(1'b1, 4'h3, 1'b1, 1'b1);
                sent3 = 1'b1;
            end else begin
                tick(1'b0, 4'h0, 1'b1, 1'b1);
            end
        end
        n_tests++;
        if (got.size() != 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d codewords, required 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (got[i] !== enc(4'(i + 1))) begin
                    n_fail++;
                    $display("FAIL bp_order_%0d: code=%h, required %h", i, got[i], enc(4'(i + 1)));
                end
            end
        end
    endtask

    task automatic test_throughput();
        int cnt0;
        cnt0 = m_cnt;
        for (int c = 0; c < 100; c++) begin
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== (q.size() != 0) || code_out !== head()) begin
                n_fail++;
                $display("FAIL tput_cycle_%0d: in_ready=%b out_valid=%b code_out=%h, required 1/%b/%h",
                         c, in_ready, out_valid, code_out, q.size() != 0, head());
            end
            if (c > 0) begin
                n_tests++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tput_rate_%0d: out_valid=%b, required 1", c, out_valid);
                end
            end
            tick(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
        end
        n_tests++;
        if (word_cnt !== 4'((cnt0 + 100) % 16) || code_out !== head()) begin
            n_fail++;
            $display("FAIL tput_end: word_cnt=%0d code_out=%h, required %0d/%h", word_cnt, code_out, (cnt0 + 100) % 16, head());
        end
        drain();
    endtask

    task automatic test_ena();
        logic [CW-1:0] held;
        logic [3:0]    cnt_held;
        tick(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
        held     = code_out;
        cnt_held = word_cnt;
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || code_out !== held || word_cnt !== cnt_held || held !== head()) begin
                n_fail++;
                $display("FAIL ena_frozen_%0d: in_ready=%b out_valid=%b code_out=%h word_cnt=%0d, required 0/1/%h/%0d",
                         c, in_ready, out_valid, code_out, word_cnt, head(), cnt_held);
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick(c < 3, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
            n_tests++;
            if (out_valid !== (q.size() != 0) || code_out !== head() || word_cnt !== m_cnt[3:0] || in_ready !== m_rdy) begin
                n_fail++;
                $display("FAIL ena_resume_%0d: out_valid=%b code_out=%h word_cnt=%0d in_ready=%b, required %b/%h/%0d/%b",
                         c, out_valid, code_out, word_cnt, in_ready, q.size() != 0, head(), m_cnt, m_rdy);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
        tick(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_full: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || word_cnt !== 4'd0 || code_out !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: out_valid=%b word_cnt=%0d code_out=%h in_ready=%b, required 0/0/0/0",
                     out_valid, word_cnt, code_out, in_ready);
        end
        q.delete();
        m_cnt = 0;
        m_rdy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 17; c++) tick(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
        n_tests++;
        if (word_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_cnt: word_cnt=%0d, required 1", word_cnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_pressure();
        test_throughput();
        test_ena();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_param.md
Name: hamming_encoder_param

Overview:
Parametrised Hamming encoder. Successor to the fixed 7,4 encoder.
- Accepts DATA_W-bit words on a valid/ready input port.
- Produces even-parity Hamming codewords on a valid/ready output port, through a 2-entry output buffer.
- Supports back-pressure and full throughput.
- Sits between the UART receive datapath and the transmit framer.

Parameters:
- DATA_W, 4: data bits per word. Legal range 1..57.
- P_W, derived: smallest P with 2^P >= DATA_W+P+1. Not overridable.
- CODE_W, derived: DATA_W+P_W, plus 1 when SECDED_EN is defined.
- CNT_W, 16: width of the encoded-word counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low = freeze all state
- in_valid  in  1  data_in is valid
- in_ready  out  1  block can accept a word this cycle
- data_in  in  DATA_W  data word; data_in[0] = d0
- out_valid  out  1  code_out holds a valid codeword
- out_ready  in  1  downstream accepts code_out this cycle
- code_out  out  CODE_W  codeword
- word_cnt  out  CNT_W  number of words accepted since reset

Behaviour:
- Reset (asynchronous, rst_n low):
  - buffer emptied
  - out_valid=0, code_out=0, word_cnt=0
  - in_ready=0 while rst_n is low; in_ready=1 on the first clk edge after release.
- Codeword layout:
  - Positions 1..DATA_W+P_W map to code_out[pos-1].
  - Parity bit p_k sits at position 2^k. Data bits fill the remaining positions in ascending order: d0 at position 3, d1 at 5, and so on.
  - p_k = XOR of all data bits whose position has bit k set (even parity).
- Buffer: 2-entry FIFO of encoded words. Encoding happens combinationally on data_in before the write.
- Accept = ena & in_valid & in_ready. Pop = ena & out_valid & out_ready.
- in_ready is registered: 1 iff the buffer count after this cycle's push/pop is < 2. It never depends combinationally on out_ready.
- Latency: a word accepted at edge N appears on code_out after edge N (1 cycle) when the buffer was empty.
- out_valid = count != 0. code_out = head entry.
- code_out and out_valid are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - count unchanged
  - full throughput of 1 word per cycle sustained
  - when the buffer is full, a push with a pop is impossible because in_ready is 0.
- ena=0:
  - no accept, no pop, count/contents/word_cnt held
  - in_ready forced 0 combinationally
  - out_valid held.
- word_cnt increments on each accept and wraps 2^CNT_W-1 -> 0.
- Reset mid-transfer drops buffered words. No partial output.

Optional Feature:
SECDED_EN
- Defined:
  - code_out[CODE_W-1] = XOR of code_out[CODE_W-2:0] (overall parity).
  - Gives single-error-correct / double-error-detect.
- Undefined:
  - no extra bit; CODE_W = DATA_W+P_W.
- Timing and handshake are identical in both builds.

Decomposition:
- Package hamming_pkg:
  - function calc_parity_w(data_w)
  - function is_pow2(pos)
  - localparam defaults for DATA_W 4/11/26/57
  - shared by the future decoder.
- Sub-module hamming_parity_gen (combinational, parametrised by DATA_W): scatters data bits into positions and computes the parity bits.
- The top module holds the FIFO, handshake and counter.

Test Plan:
- DATA_W=4, no SECDED, reset then in_valid=1, data_in=4'b1011, out_ready=1:
  - code_out=7'h55, out_valid=1 one cycle after accept
  - word_cnt=1.
- DATA_W=4, SECDED_EN defined:
  - data_in=4'hF -> code_out=8'hFF
  - data_in=4'b1011 -> 8'h55
  - data_in=4'h0 -> 8'h00.
- Back-pressure:
  - out_ready=0, stream 0x1,0x2,0x3 -> in_ready drops after 2 accepts
  - codewords for 0x1,0x2 held; 0x3 not accepted until out_ready=1
  - output order preserved.
- Throughput: in_valid=out_ready=1 for 100 cycles with random data -> one codeword per cycle, word_cnt=100, each codeword matches the reference model.
- ena toggled low mid-stream with a pending output:
  - out_valid/code_out/word_cnt frozen, in_ready=0
  - resumes without loss when ena returns to 1.
- Async reset with a full buffer:
  - rst_n low between edges -> out_valid=0, word_cnt=0 immediately
  - in_ready=1 one edge after release.
- Wrap check: CNT_W=4, 17 accepts -> word_cnt=1.
